ether_unpacker: RTL and testbench

Inverse of the 12-to-16 Ethernet packing path. Takes 16-bit words from the Ethernet receive interface and restores the original 12-bit event-data stream: every 3 input words become 4 output words. It sits between the Ethernet RX interface and the 12-bit event-data consumers, such as the loopback checker or the command/data parser. It supports backpressure, trailing-pad discard on the final word of a run, and run abort.

---
 rtl/ether_unpacker.sv | 135 +++++++++++++
 tb/tb_ether_unpacker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ether_unpacker.sv
// ether_unpacker: restores a 12-bit event-data stream from 16-bit Ethernet RX
// words (3 input words -> 4 output words), with backpressure, trailing-pad
// discard and run abort.
// Optional build macro UNPACK_PADCHK_EN: when defined, PadErr flags nonzero
// discarded pad bits; when undefined, PadErr is tied low.
//
// Handshake: a word is transferred on a clock edge where StrobeIn=1 and
// ReadyIn=1; StrobeIn while ReadyIn=0 drops the word and sets sticky Overrun.
module ether_unpacker #(
    parameter int CNT_W = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      DataIn,
    input  logic             StrobeIn,
    input  logic             PadIn,
    input  logic             endRun,
    output logic             ReadyIn,
    output logic [11:0]      DataOut,
    output logic             StrobeOut,
    output logic [CNT_W-1:0] WordCnt,
    output logic             Overrun,
    output logic             PadErr
);

    // One-hot phase: number of leftover bits held (0, 4, 8, 12)
    localparam logic [3:0] P0 = 4'b0001;
    localparam logic [3:0] P1 = 4'b0010;
    localparam logic [3:0] P2 = 4'b0100;
    localparam logic [3:0] P3 = 4'b1000;

    logic [3:0]  phase;
    logic [3:0]  phaseNext;
    logic [11:0] hold;
    logic [11:0] holdNext;
    logic [11:0] dataNext;
    logic        strobeNext;
    logic        accept;

    // P3 is the drain cycle for the fully held word, so no input is taken then
    assign ReadyIn = (phase != P3);
    assign accept  = StrobeIn && ReadyIn;

    // Phase register; Reset returns to P0
    always_ff @(posedge Clock) begin
        if (Reset) phase <= P0;
        else       phase <= phaseNext;
    end

    // Next phase: pad or endRun always closes the run, illegal codes recover to P0
    always_comb begin
        phaseNext = P0;
        case (phase)
            P0, P1, P2: begin
                if (endRun || (accept && PadIn)) phaseNext = P0;
                else if (accept)                 phaseNext = {phase[2:0], 1'b0};
                else                             phaseNext = phase;
            end
            P3:      phaseNext = P0;
            default: phaseNext = P0;
        endcase
    end

    // Output/datapath decode: which 12 bits complete this cycle and what is left over
    always_comb begin
        dataNext   = DataOut;
        strobeNext = 1'b0;
        holdNext   = hold;
        case (phase)
            P0: if (accept) begin
                dataNext      = DataIn[15:4];
                strobeNext    = 1'b1;
                holdNext[3:0] = DataIn[3:0];
            end
            P1: if (accept) begin
                dataNext      = {hold[3:0], DataIn[15:8]};
                strobeNext    = 1'b1;
                holdNext[7:0] = DataIn[7:0];
            end
            P2: if (accept) begin
                dataNext   = {hold[7:0], DataIn[15:12]};
                strobeNext = 1'b1;
                holdNext   = DataIn[11:0];
            end
            P3: begin
                dataNext   = hold;
                strobeNext = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs, emitted-word counter and sticky overrun flag
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold      <= '0;
            DataOut   <= '0;
            StrobeOut <= 1'b0;
            WordCnt   <= '0;
            Overrun   <= 1'b0;
        end else begin
            hold      <= holdNext;
            DataOut   <= dataNext;
            StrobeOut <= strobeNext;
            if (strobeNext)
                WordCnt <= WordCnt + CNT_W'(1);
            if (StrobeIn && !ReadyIn)
                Overrun <= 1'b1;
        end
    end

`ifdef UNPACK_PADCHK_EN
    logic padDirty;

    // Pad bits that a pad word discards in the current phase are nonzero
    always_comb begin
        padDirty = 1'b0;
        case (phase)
            P0:      padDirty = |DataIn[3:0];
            P1:      padDirty = |DataIn[7:0];
            P2:      padDirty = |DataIn[11:0];
            default: padDirty = 1'b0;
        endcase
    end

    // PadErr pulse aligned with the pad word's StrobeOut
    always_ff @(posedge Clock) begin
        if (Reset) PadErr <= 1'b0;
        else       PadErr <= accept && PadIn && padDirty;
    end
`else
    assign PadErr = 1'b0;
`endif

endmodule

// File: tb/tb_ether_unpacker.sv
// tb_ether_unpacker: directed vector table, hand-written corner sequences and
// a randomized run against a bit-queue reference model.
module tb_ether_unpacker;

    localparam int CNT_W = 24;
`ifdef UNPACK_PADCHK_EN
    localparam logic PADCHK = 1'b1;
`else
    localparam logic PADCHK = 1'b0;
`endif

    logic             Clock;
    logic             Reset;
    logic [15:0]      DataIn;
    logic             StrobeIn;
    logic             PadIn;
    logic             endRun;
    logic             ReadyIn;
    logic [11:0]      DataOut;
    logic             StrobeOut;
    logic [CNT_W-1:0] WordCnt;
    logic             Overrun;
    logic             PadErr;

    ether_unpacker #(.CNT_W(CNT_W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DataIn   (DataIn),
        .StrobeIn (StrobeIn),
        .PadIn    (PadIn),
        .endRun   (endRun),
        .ReadyIn  (ReadyIn),
        .DataOut  (DataOut),
        .StrobeOut(StrobeOut),
        .WordCnt  (WordCnt),
        .Overrun  (Overrun),
        .PadErr   (PadErr)
    );

    // Clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and return 1 time unit after the edge
    task automatic step(input logic rst, input logic stb, input logic pad,
                        input logic er, input logic [15:0] din);
        Reset    = rst;
        StrobeIn = stb;
        PadIn    = pad;
        endRun   = er;
        DataIn   = din;
        @(posedge Clock);
        #1;
        Reset    = 1'b0;
        StrobeIn = 1'b0;
        PadIn    = 1'b0;
        endRun   = 1'b0;
        DataIn   = 16'h0;
    endtask

    typedef struct {
        logic        rst;
        logic        stb;
        logic        pad;
        logic        er;
        logic [15:0] din;
        logic        expStb;
        logic [11:0] expDout;
        logic        expRdy;
        int          expCnt;
        logic        expOvr;
    } vec_t;

    vec_t tbl[27];

    // Reference model state: the unconsumed input bit stream, MSB first
    bit          mq[$];
    logic [11:0] mLast;
    int          mCnt;
    logic        mOvr;

    task automatic model_reset();
        mq.delete();
        mLast = 12'h0;
        mCnt  = 0;
        mOvr  = 1'b0;
    endtask

    function automatic logic [11:0] pop12();
        logic [11:0] v;
        v = 12'h0;
        repeat (12) v = {v[10:0], logic'(mq.pop_front())};
        return v;
    endfunction

    initial begin
        logic rst, stb, pad, er;
        logic [15:0] din;
        logic expStb, expPe, dirty;

        Reset = 1'b1; StrobeIn = 1'b0; PadIn = 1'b0; endRun = 1'b0; DataIn = 16'h0;

        //              rst  stb  pad  er   din       stb  dout    rdy  cnt ovr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 1'b1, 0,  1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 12'hABC, 1'b1, 1,  1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12, 1'b1, 12'hDEF, 1'b1, 2,  1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3456, 1'b1, 12'h123, 1'b0, 3,  1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 12'h456, 1'b1, 4,  1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h456, 1'b1, 4,  1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hABC0, 1'b1, 12'hABC, 1'b1, 5,  1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 12'h123, 1'b1, 6,  1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 12'h123, 1'b1, 6,  1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 12'hABC, 1'b1, 7,  1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hEF00, 1'b1, 12'hDEF, 1'b1, 8,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 12'hDEF, 1'b1, 8,  1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 12'hABC, 1'b1, 9,  1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12, 1'b1, 12'hDEF, 1'b1, 10, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 12'hDEF, 1'b1, 10, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h7898, 1'b1, 12'h789, 1'b1, 11, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 12'h789, 1'b1, 11, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 12'hABC, 1'b1, 12, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12, 1'b1, 12'hDEF, 1'b1, 13, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3456, 1'b1, 12'h123, 1'b0, 14, 1'b0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 12'h456, 1'b1, 15, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h456, 1'b1, 15, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD, 1'b1, 12'hABC, 1'b1, 16, 1'b1};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12, 1'b1, 12'hDEF, 1'b1, 17, 1'b1};
        tbl[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3456, 1'b1, 12'h123, 1'b0, 18, 1'b1};
        tbl[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 12'h000, 1'b1, 0,  1'b0};
        tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 12'h123, 1'b1, 1,  1'b0};

        // Directed vector table
        for (int i = 0; i < 27; i++) begin
            step(tbl[i].rst, tbl[i].stb, tbl[i].pad, tbl[i].er, tbl[i].din);
            check($sformatf("vec%0d StrobeOut", i), 32'(StrobeOut), 32'(tbl[i].expStb));
            check($sformatf("vec%0d DataOut", i),   32'(DataOut),   32'(tbl[i].expDout));
            check($sformatf("vec%0d ReadyIn", i),   32'(ReadyIn),   32'(tbl[i].expRdy));
            check($sformatf("vec%0d WordCnt", i),   32'(WordCnt),   32'(tbl[i].expCnt));
            check($sformatf("vec%0d Overrun", i),   32'(Overrun),   32'(tbl[i].expOvr));
            check($sformatf("vec%0d PadErr", i),    32'(PadErr),    32'd0);
        end

        // Close the run left open in P1
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("close StrobeOut", 32'(StrobeOut), 32'd0);

        // Nonzero pad bits on a two-word run
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD);
        check("padbad w0 DataOut", 32'(DataOut), 32'hABC);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hEF05);
        check("padbad StrobeOut", 32'(StrobeOut), 32'd1);
        check("padbad DataOut",   32'(DataOut),   32'hDEF);
        check("padbad PadErr",    32'(PadErr),    32'(PADCHK));
        check("padbad ReadyIn",   32'(ReadyIn),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("padbad tail StrobeOut", 32'(StrobeOut), 32'd0);
        check("padbad tail PadErr",    32'(PadErr),    32'd0);

        // endRun together with an accepted word in P2: word emitted, 12 held bits dropped
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h3456);
        check("erP2 StrobeOut", 32'(StrobeOut), 32'd1);
        check("erP2 DataOut",   32'(DataOut),   32'h123);
        check("erP2 ReadyIn",   32'(ReadyIn),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("erP2 tail StrobeOut", 32'(StrobeOut), 32'd0);

        // endRun in P3: held word still emitted
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hABCD);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'hEF12);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3456);
        check("erP3 pre ReadyIn", 32'(ReadyIn), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        check("erP3 StrobeOut", 32'(StrobeOut), 32'd1);
        check("erP3 DataOut",   32'(DataOut),   32'h456);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
        check("erP3 next DataOut", 32'(DataOut), 32'h123);

        // Randomized run against the bit-stream model
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        model_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            stb = ($urandom_range(0, 99) < 75);
            pad = ($urandom_range(0, 99) < 10);
            er  = ($urandom_range(0, 99) < 6);
            din = 16'($urandom);
            if ($urandom_range(0, 3) == 0) din[11:0] = 12'h0;

            expStb = 1'b0;
            expPe  = 1'b0;
            if (rst) begin
                model_reset();
            end else begin
                if (mq.size() == 12) begin
                    mLast  = pop12();
                    expStb = 1'b1;
                    if (stb) mOvr = 1'b1;
                end else if (stb) begin
                    for (int b = 15; b >= 0; b--) mq.push_back(din[b]);
                    mLast  = pop12();
                    expStb = 1'b1;
                    if (pad) begin
                        dirty = 1'b0;
                        foreach (mq[k]) if (mq[k]) dirty = 1'b1;
                        mq.delete();
                        expPe = dirty & PADCHK;
                    end
                end
                if (er) mq.delete();
                if (expStb) mCnt++;
            end

            step(rst, stb, pad, er, din);
            check($sformatf("rnd%0d StrobeOut", c), 32'(StrobeOut), 32'(expStb));
            check($sformatf("rnd%0d DataOut", c),   32'(DataOut),   32'(mLast));
            check($sformatf("rnd%0d ReadyIn", c),   32'(ReadyIn),   32'(mq.size() != 12));
            check($sformatf("rnd%0d WordCnt", c),   32'(WordCnt),   32'(mCnt % (1 << CNT_W)));
            check($sformatf("rnd%0d Overrun", c),   32'(Overrun),   32'(mOvr));
            check($sformatf("rnd%0d PadErr", c),    32'(PadErr),    32'(expPe));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
